// File: rtl/nec_ir_pkg.sv
// Shared types and tick-window bounds for the NEC IR receiver.
// All durations are in sample ticks (35 us nominal).
package nec_ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK
  } state_t;

  typedef logic [8:0] cnt_t;
  localparam cnt_t CNT_MAX = 9'd511;

  localparam logic [1:0] ERR_TIMING  = 2'b00;
  localparam logic [1:0] ERR_INV     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  localparam cnt_t LEAD_MARK_LO  = 9'd218;
  localparam cnt_t LEAD_MARK_HI  = 9'd296;
  localparam cnt_t LEAD_SPACE_LO = 9'd89;
  localparam cnt_t LEAD_SPACE_HI = 9'd167;
  localparam cnt_t REP_SPACE_LO  = 9'd48;
  localparam cnt_t REP_SPACE_HI  = 9'd80;
  // Bit mark, zero space and stop mark all share the 560 us window.
  localparam cnt_t SHORT_LO      = 9'd7;
  localparam cnt_t SHORT_HI      = 9'd25;
  localparam cnt_t ONE_SPACE_LO  = 9'd39;
  localparam cnt_t ONE_SPACE_HI  = 9'd57;

  function automatic logic in_win(input cnt_t c, input cnt_t lo, input cnt_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_timer.sv
// Tick prescaler plus saturating 9-bit duration counter; both restart
// whenever the synchronised line changes level.
module nec_ir_timer
  import nec_ir_pkg::*;
#(
  parameter int unsigned DIV = 1750
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output cnt_t cnt
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt   <= '0;
    end else if (clr) begin
      pre_q <= '0;
      cnt   <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/nec_ir_rx.sv
// NEC IR frame receiver: synchroniser, pulse-width FSM, complement check and
// a valid/ready output register with overrun detection.
module nec_ir_rx
  import nec_ir_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_US     = 35,
  parameter int unsigned CHECK_INV   = 1,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IR,
  output logic [31:0] frame_data,
  output logic [7:0]  frame_cmd,
  output logic [7:0]  frame_addr,
  output logic        frame_rep,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        err_pulse,
  output logic [1:0]  err_code
);

  localparam logic [63:0] DIV_L =
    (64'(CLK_HZ) * 64'(TICK_US) + 64'd500_000) / 64'd1_000_000;
  localparam int unsigned DIV = (DIV_L == 64'd0) ? 1 : 32'(DIV_L);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   fall, rise;
  cnt_t                   cnt;

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q;
  logic [31:0] shift_q;
  logic        rep_q, have_last_q;

  logic timing_err, timeout, do_shift, shift_bit, start_data, start_rep, done;
  logic inv_ok, present, overrun, accept, err_now;
  logic [1:0] err_code_d;

  // Synchroniser resets to the idle level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], IR};
  end

  assign fall = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
  assign rise = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-2];

  nec_ir_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fall | rise),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    timing_err = 1'b0;
    timeout    = 1'b0;
    do_shift   = 1'b0;
    shift_bit  = 1'b0;
    start_data = 1'b0;
    start_rep  = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: if (fall) state_d = ST_LEAD_MARK;
      ST_LEAD_MARK: if (rise) begin
        if (in_win(cnt, LEAD_MARK_LO, LEAD_MARK_HI)) state_d = ST_LEAD_SPACE;
        else timing_err = 1'b1;
      end
      ST_LEAD_SPACE: if (fall) begin
        if (in_win(cnt, LEAD_SPACE_LO, LEAD_SPACE_HI)) begin
          state_d = ST_BIT_MARK;  start_data = 1'b1;
        end else if (in_win(cnt, REP_SPACE_LO, REP_SPACE_HI)) begin
          state_d = ST_STOP_MARK; start_rep = 1'b1;
        end else timing_err = 1'b1;
      end
      ST_BIT_MARK: if (rise) begin
        if (in_win(cnt, SHORT_LO, SHORT_HI)) state_d = ST_BIT_SPACE;
        else timing_err = 1'b1;
      end
      ST_BIT_SPACE: if (fall) begin
        if (in_win(cnt, SHORT_LO, SHORT_HI)) do_shift = 1'b1;
        else if (in_win(cnt, ONE_SPACE_LO, ONE_SPACE_HI)) begin
          do_shift = 1'b1; shift_bit = 1'b1;
        end else timing_err = 1'b1;
        if (do_shift) state_d = (bit_cnt_q == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
      end
      ST_STOP_MARK: if (rise) begin
        if (in_win(cnt, SHORT_LO, SHORT_HI)) begin
          done = 1'b1; state_d = ST_IDLE;
        end else timing_err = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && !(fall || rise) && cnt == CNT_MAX) timeout = 1'b1;
    if (timing_err || timeout) state_d = ST_IDLE;
  end

  // Completion decisions: repeats need a prior frame, data frames the check.
  always_comb begin
    inv_ok     = (CHECK_INV == 0) || (shift_q[15:8] == ~shift_q[7:0]);
    present    = done && (rep_q ? have_last_q : inv_ok);
    overrun    = present && frame_valid && !frame_ready;
    accept     = present && !overrun;
    err_now    = timing_err || timeout || (done && !rep_q && !inv_ok) || overrun;
    err_code_d = ERR_TIMING;
    if (timeout)                    err_code_d = ERR_TIMEOUT;
    else if (overrun)               err_code_d = ERR_OVERRUN;
    else if (done && !rep_q && !inv_ok) err_code_d = ERR_INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rep_q       <= 1'b0;
      have_last_q <= 1'b0;
      frame_data  <= '0;
      frame_rep   <= 1'b0;
      frame_valid <= 1'b0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_TIMING;
    end else begin
      if (start_data) begin
        bit_cnt_q <= '0;
        rep_q     <= 1'b0;
      end
      if (start_rep) rep_q <= 1'b1;
      if (do_shift) begin
        shift_q   <= {shift_q[30:0], shift_bit};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      // A repeat re-presents the held word, so only data frames load it.
      if (accept) begin
        frame_valid <= 1'b1;
        frame_rep   <= rep_q;
        if (!rep_q) begin
          frame_data  <= shift_q;
          have_last_q <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      err_pulse <= err_now;
      if (err_now) err_code <= err_code_d;
    end
  end

  assign frame_cmd  = frame_data[7:0];
  assign frame_addr = frame_data[23:16];

endmodule

// File: tb/tb_nec_ir_rx.sv
// Randomised NEC waveform bench for nec_ir_rx, scored against a word-level
// model of what the receiver should present or report.
module tb_nec_ir_rx;
  import nec_ir_pkg::*;

  localparam int P = 2;  // clocks per tick at CLK_HZ=57_143, TICK_US=35

  logic        clk = 1'b0;
  logic        rst_n, IR, frame_ready;
  logic [31:0] frame_data, ni_data;
  logic [7:0]  frame_cmd, frame_addr, ni_cmd, ni_addr;
  logic        frame_rep, frame_valid, err_pulse, ni_rep, ni_valid, ni_err_pulse;
  logic [1:0]  err_code, ni_err_code;

  int tests_run = 0;
  int tests_failed = 0;
  int valid_cycles = 0;

  logic [32:0] acc_q[$];
  logic [32:0] ni_acc_q[$];
  logic [1:0]  err_q[$];

  bit          have_last = 1'b0;
  logic [31:0] last_word = '0;

  nec_ir_rx #(.CLK_HZ(57_143), .TICK_US(35), .CHECK_INV(1), .SYNC_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .IR(IR), .frame_data(frame_data), .frame_cmd(frame_cmd),
    .frame_addr(frame_addr), .frame_rep(frame_rep), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .err_pulse(err_pulse), .err_code(err_code));

  nec_ir_rx #(.CLK_HZ(57_143), .TICK_US(35), .CHECK_INV(0), .SYNC_STAGES(3)) dut_ni (
    .clk(clk), .rst_n(rst_n), .IR(IR), .frame_data(ni_data), .frame_cmd(ni_cmd),
    .frame_addr(ni_addr), .frame_rep(ni_rep), .frame_valid(ni_valid),
    .frame_ready(frame_ready), .err_pulse(ni_err_pulse), .err_code(ni_err_code));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) valid_cycles++;
    if (frame_valid && frame_ready) acc_q.push_back({frame_rep, frame_data});
    if (err_pulse) err_q.push_back(err_code);
    if (ni_valid && frame_ready) ni_acc_q.push_back({ni_rep, ni_data});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int jit(input int nom, input int j);
    return nom - j + int'($urandom_range(2 * j, 0));
  endfunction

  task automatic mark(input int t);
    IR = 1'b0;
    step(t * P);
  endtask

  task automatic space(input int t);
    IR = 1'b1;
    step(t * P);
  endtask

  task automatic send_frame(input logic [31:0] w);
    mark(jit(257, 15));
    space(jit(128, 15));
    for (int i = 31; i >= 0; i--) begin
      mark(jit(16, 4));
      space(w[i] ? jit(48, 4) : jit(16, 4));
    end
    mark(jit(16, 4));
    space(60);
  endtask

  task automatic send_repeat();
    mark(jit(257, 15));
    space(jit(64, 6));
    mark(jit(16, 4));
    space(60);
  endtask

  task automatic clear_obs();
    acc_q.delete();
    ni_acc_q.delete();
    err_q.delete();
    valid_cycles = 0;
  endtask

  function automatic logic [31:0] valid_word();
    logic [31:0] w;
    w = $urandom;
    w[15:8] = ~w[7:0];
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; IR = 1'b1; frame_ready = 1'b1;
    step(4);
    @(negedge clk);
    tests_run++;
    if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    tests_run++;
    if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_err_pulse: got %b expected 0", err_pulse); end
    tests_run++;
    if (frame_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", frame_data); end
    tests_run++;
    if (err_code !== 2'b00) begin tests_failed++; $display("FAIL reset_err_code: got %b expected 00", err_code); end
    step(1);
    rst_n = 1'b1;
    step(10);
  endtask

  task automatic test_repeat_after_reset();
    clear_obs();
    send_repeat();
    @(negedge clk);
    tests_run++;
    if (acc_q.size() != 0) begin tests_failed++; $display("FAIL rep_after_reset_valid: got %0d frames expected 0", acc_q.size()); end
    tests_run++;
    if (err_q.size() != 0) begin tests_failed++; $display("FAIL rep_after_reset_err: got %0d errors expected 0", err_q.size()); end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    w = 32'h00FF45BA;
    clear_obs();
    send_frame(w);
    have_last = 1'b1; last_word = w;
    @(negedge clk);
    tests_run++;
    if (acc_q.size() != 1 || acc_q[0] !== {1'b0, w}) begin
      tests_failed++; $display("FAIL basic_frame: got %0d frames first %h expected 1 frame %h", acc_q.size(), acc_q.size() ? acc_q[0] : 33'h0, {1'b0, w});
    end
    tests_run++;
    if (valid_cycles != 1) begin tests_failed++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cycles); end
    tests_run++;
    if (frame_cmd !== w[7:0]) begin tests_failed++; $display("FAIL basic_cmd: got %h expected %h", frame_cmd, w[7:0]); end
    tests_run++;
    if (frame_addr !== w[23:16]) begin tests_failed++; $display("FAIL basic_addr: got %h expected %h", frame_addr, w[23:16]); end
    tests_run++;
    if (err_q.size() != 0) begin tests_failed++; $display("FAIL basic_err: got %0d errors expected 0", err_q.size()); end
  endtask

  task automatic test_repeat();
    int exp_n;
    clear_obs();
    send_repeat();
    exp_n = have_last ? 1 : 0;
    @(negedge clk);
    tests_run++;
    if (acc_q.size() != exp_n) begin tests_failed++; $display("FAIL repeat_count: got %0d expected %0d", acc_q.size(), exp_n); end
    tests_run++;
    if (exp_n == 1 && acc_q.size() == 1 && acc_q[0] !== {1'b1, last_word}) begin
      tests_failed++; $display("FAIL repeat_frame: got %h expected %h", acc_q[0], {1'b1, last_word});
    end
  endtask

  task automatic test_complement();
    logic [31:0] w;
    w = 32'h00FF4545;
    clear_obs();
    send_frame(w);
    @(negedge clk);
    tests_run++;
    if (err_q.size() != 1 || err_q[0] !== ERR_INV) begin
      tests_failed++; $display("FAIL inv_err: got %0d errors code %b expected 1 error code 01", err_q.size(), err_q.size() ? err_q[0] : 2'b00);
    end
    tests_run++;
    if (acc_q.size() != 0) begin tests_failed++; $display("FAIL inv_no_valid: got %0d frames expected 0", acc_q.size()); end
    tests_run++;
    if (ni_acc_q.size() != 1 || ni_acc_q[0] !== {1'b0, w}) begin
      tests_failed++; $display("FAIL noinv_frame: got %0d frames expected 1 frame %h", ni_acc_q.size(), w);
    end
    tests_run++;
    if (err_code !== ERR_INV) begin tests_failed++; $display("FAIL inv_err_code_hold: got %b expected 01", err_code); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 0) ? valid_word() : $urandom;
      ok = (w[15:8] == ~w[7:0]);
      clear_obs();
      send_frame(w);
      if (ok) begin have_last = 1'b1; last_word = w; end
      @(negedge clk);
      tests_run++;
      if (ok && (acc_q.size() != 1 || acc_q[0] !== {1'b0, w})) begin
        tests_failed++; $display("FAIL rand_frame_%0d: got %0d frames expected word %h", i, acc_q.size(), w);
      end else if (!ok && (acc_q.size() != 0 || err_q.size() != 1 || err_q[0] !== ERR_INV)) begin
        tests_failed++; $display("FAIL rand_inv_%0d: got %0d frames %0d errors expected complement error for %h", i, acc_q.size(), err_q.size(), w);
      end
      tests_run++;
      if (frame_data !== last_word) begin tests_failed++; $display("FAIL rand_held_%0d: got %h expected %h", i, frame_data, last_word); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] wa, wb;
    wa = valid_word();
    wb = valid_word();
    frame_ready = 1'b0;
    clear_obs();
    send_frame(wa);
    have_last = 1'b1; last_word = wa;
    @(negedge clk);
    tests_run++;
    if (frame_valid !== 1'b1 || frame_data !== wa) begin
      tests_failed++; $display("FAIL ovr_first: got valid %b data %h expected 1 %h", frame_valid, frame_data, wa);
    end
    send_frame(wb);
    @(negedge clk);
    tests_run++;
    if (err_q.size() != 1 || err_q[0] !== ERR_OVERRUN) begin
      tests_failed++; $display("FAIL ovr_err: got %0d errors code %b expected code 11", err_q.size(), err_code);
    end
    tests_run++;
    if (frame_valid !== 1'b1 || frame_data !== wa || frame_rep !== 1'b0) begin
      tests_failed++; $display("FAIL ovr_held: got valid %b data %h expected 1 %h", frame_valid, frame_data, wa);
    end
    step(1);
    frame_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (frame_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_handshake_cycle: got %b expected 1", frame_valid); end
    @(negedge clk);
    tests_run++;
    if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_drop: got %b expected 0", frame_valid); end
    tests_run++;
    if (acc_q.size() != 1 || acc_q[0] !== {1'b0, wa}) begin
      tests_failed++; $display("FAIL ovr_accepted: got %0d frames expected 1 frame %h", acc_q.size(), wa);
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    mark(571);
    space(40);
    @(negedge clk);
    tests_run++;
    if (err_q.size() != 1 || err_q[0] !== ERR_TIMEOUT) begin
      tests_failed++; $display("FAIL timeout_err: got %0d errors code %b expected 1 error code 10", err_q.size(), err_code);
    end
    tests_run++;
    if (acc_q.size() != 0) begin tests_failed++; $display("FAIL timeout_no_valid: got %0d frames expected 0", acc_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = valid_word();
    clear_obs();
    mark(257);
    space(128);
    for (int i = 31; i >= 20; i--) begin
      mark(16);
      space(w[i] ? 48 : 16);
    end
    mark(8);
    rst_n = 1'b0;
    IR = 1'b1;
    step(3);
    @(negedge clk);
    tests_run++;
    if ({frame_valid, frame_rep, err_pulse, err_code, frame_data} !== 37'h0) begin
      tests_failed++; $display("FAIL midreset_outputs: got valid %b rep %b pulse %b code %b data %h expected all 0", frame_valid, frame_rep, err_pulse, err_code, frame_data);
    end
    step(1);
    rst_n = 1'b1;
    have_last = 1'b0;
    step(50);
    @(negedge clk);
    tests_run++;
    if (dut.state_q !== ST_IDLE) begin tests_failed++; $display("FAIL midreset_state: got %0d expected IDLE", dut.state_q); end
    tests_run++;
    if (err_q.size() != 0) begin tests_failed++; $display("FAIL midreset_err: got %0d errors expected 0", err_q.size()); end
    tests_run++;
    if (frame_data !== 32'h0 || frame_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_after: got data %h valid %b expected 0 0", frame_data, frame_valid);
    end
  endtask

  initial begin
    test_reset();
    test_repeat_after_reset();
    test_basic();
    test_repeat();
    test_complement();
    test_random();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
